// File: rtl/prt_arbiter_if.sv
// Request/grant bundle between the requesting units and prt_arbiter.
// master = requester side, slave = arbiter side.
interface prt_arbiter_if;
   localparam int unsigned N_REQ = 4;
   localparam int unsigned ID_W  = 2;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_id;
   logic             busy;

   modport master (output req, input gnt, input gnt_id, input busy);
   modport slave  (input req, output gnt, output gnt_id, output busy);
endinterface

// File: rtl/prt_arbiter.sv
// Four-requester bus arbiter: fixed (index 3 highest) or round-robin priority,
// grant held until release, bounded hold in RR mode, one dead cycle per handover.
module prt_arbiter #(
   parameter bit          RR_EN    = 1'b1,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   prt_arbiter_if.slave bus
);

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned ID_W   = 2;
   localparam int unsigned HOLD_W = 8;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_GAP  = 2'd2
   } state_e;

   // 4-to-2 priority encode: index of the highest set bit, 0 when empty.
   function automatic logic [ID_W-1:0] prio_enc(input logic [N_REQ-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (v[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [N_REQ-1:0] bit_rev(input logic [N_REQ-1:0] v);
      logic [N_REQ-1:0] r;
      for (int i = 0; i < int'(N_REQ); i++) r[i] = v[int'(N_REQ) - 1 - i];
      return r;
   endfunction

   state_e              state_q, state_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
   logic                busy_q, busy_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

   logic [2*N_REQ-1:0]  req_dbl_c;
   logic [N_REQ-1:0]    req_rot_c;
   logic [ID_W-1:0]     win_rr_c;
   logic [ID_W-1:0]     win_fx_c;
   logic [ID_W-1:0]     win_c;
   logic                owner_req_c;
   logic                others_c;

   // RR: rotate so req[ptr] lands at bit 0, then take the lowest set bit.
   always_comb begin
      req_dbl_c = {bus.req, bus.req} >> ptr_q;
      req_rot_c = req_dbl_c[N_REQ-1:0];
      win_rr_c  = ptr_q + (ID_W'(N_REQ - 1) - prio_enc(bit_rev(req_rot_c)));
      win_fx_c  = prio_enc(bus.req);
      win_c     = RR_EN ? win_rr_c : win_fx_c;
      owner_req_c = bus.req[gnt_id_q];
      others_c    = |(bus.req & ~gnt_q);
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      busy_d     = busy_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;

      unique case (state_q)
         S_IDLE, S_GAP: begin
            if (|bus.req) begin
               state_d    = S_BUSY;
               gnt_d      = N_REQ'(1) << win_c;
               gnt_id_d   = win_c;
               busy_d     = 1'b1;
               hold_cnt_d = HOLD_W'(1);
            end else begin
               state_d = S_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         S_BUSY: begin
            // Release and preemption share one path, so a coinciding drop also advances ptr.
            if (!owner_req_c || (RR_EN && (hold_cnt_q == HOLD_MAX) && others_c)) begin
               state_d = S_GAP;
               gnt_d   = '0;
               busy_d  = 1'b0;
               ptr_d   = gnt_id_q + ID_W'(1);
            end else if (hold_cnt_q < HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else begin
               hold_cnt_d = HOLD_MAX;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         busy_q     <= 1'b0;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         busy_q     <= busy_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.gnt_id = gnt_id_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_prt_arbiter.sv
// Directed bench for prt_arbiter: one RR instance (MAX_HOLD=2) and one fixed-priority instance.
module tb_prt_arbiter;

   logic clk;
   logic rst_n;
   int   tests;
   int   errors;

   prt_arbiter_if rbus ();
   prt_arbiter_if fbus ();

   prt_arbiter #(.RR_EN(1'b1), .MAX_HOLD(2)) u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (rbus.slave)
   );

   prt_arbiter #(.RR_EN(1'b0), .MAX_HOLD(8)) u_fx (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (fbus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rbus.req = 4'b0000;
      fbus.req = 4'b0000;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rbus.req = 4'b1111;
      fbus.req = 4'b0000;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (rbus.gnt !== 4'b0000 || rbus.gnt_id !== 2'b00 || rbus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold[%0d] got gnt=%b id=%b busy=%b want 0000/00/0",
                     i, rbus.gnt, rbus.gnt_id, rbus.busy);
         end
         tick();
      end
      rst_n = 1'b1;
      tick();
      tests++;
      if (rbus.gnt !== 4'b0001 || rbus.gnt_id !== 2'b00 || rbus.busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_grant got gnt=%b id=%b busy=%b want 0001/00/1",
                  rbus.gnt, rbus.gnt_id, rbus.busy);
      end
      rbus.req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_fixed();
      do_reset();
      fbus.req = 4'b0101;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++;
         if (fbus.gnt !== 4'b0100 || fbus.gnt_id !== 2'b10 || fbus.busy !== 1'b1) begin
            errors++;
            $display("FAIL fixed_hold[%0d] got gnt=%b id=%b busy=%b want 0100/10/1",
                     i, fbus.gnt, fbus.gnt_id, fbus.busy);
         end
      end
      fbus.req = 4'b0001;
      tick();
      tests++;
      if (fbus.gnt !== 4'b0000 || fbus.gnt_id !== 2'b10 || fbus.busy !== 1'b0) begin
         errors++;
         $display("FAIL fixed_gap got gnt=%b id=%b busy=%b want 0000/10/0",
                  fbus.gnt, fbus.gnt_id, fbus.busy);
      end
      tick();
      tests++;
      if (fbus.gnt !== 4'b0001 || fbus.gnt_id !== 2'b00) begin
         errors++;
         $display("FAIL fixed_next got gnt=%b id=%b want 0001/00", fbus.gnt, fbus.gnt_id);
      end
      fbus.req = 4'b0000;
      tick();
      tick();
      tests++;
      if (fbus.gnt !== 4'b0000 || fbus.busy !== 1'b0) begin
         errors++;
         $display("FAIL fixed_idle got gnt=%b busy=%b want 0000/0", fbus.gnt, fbus.busy);
      end
   endtask

   task automatic test_rr_rotation();
      logic [3:0] exp_gnt [14];
      logic [1:0] exp_id  [14];
      exp_gnt = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                  4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
      exp_id  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                  2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
      do_reset();
      rbus.req = 4'b1111;
      for (int i = 0; i < 14; i++) begin
         tick();
         tests++;
         if (rbus.gnt !== exp_gnt[i] || rbus.gnt_id !== exp_id[i] ||
             rbus.busy !== (|exp_gnt[i])) begin
            errors++;
            $display("FAIL rr_rot[%0d] got gnt=%b id=%b busy=%b want %b/%b/%b",
                     i, rbus.gnt, rbus.gnt_id, rbus.busy, exp_gnt[i], exp_id[i], |exp_gnt[i]);
         end
      end
      rbus.req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_lone();
      do_reset();
      rbus.req = 4'b1000;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++;
         if (rbus.gnt !== 4'b1000 || rbus.gnt_id !== 2'b11) begin
            errors++;
            $display("FAIL lone_hold[%0d] got gnt=%b id=%b want 1000/11", i, rbus.gnt, rbus.gnt_id);
         end
      end
      rbus.req = 4'b1001;
      tick();
      tests++;
      if (rbus.gnt !== 4'b0000) begin
         errors++;
         $display("FAIL lone_preempt_gap got gnt=%b want 0000", rbus.gnt);
      end
      tick();
      tests++;
      if (rbus.gnt !== 4'b0001 || rbus.gnt_id !== 2'b00) begin
         errors++;
         $display("FAIL lone_next got gnt=%b id=%b want 0001/00", rbus.gnt, rbus.gnt_id);
      end
      rbus.req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      rbus.req = 4'b0010;
      tick();
      tests++;
      if (rbus.gnt !== 4'b0010) begin
         errors++;
         $display("FAIL arst_pre got gnt=%b want 0010", rbus.gnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (rbus.gnt !== 4'b0000 || rbus.gnt_id !== 2'b00 || rbus.busy !== 1'b0) begin
         errors++;
         $display("FAIL arst_mid got gnt=%b id=%b busy=%b want 0000/00/0",
                  rbus.gnt, rbus.gnt_id, rbus.busy);
      end
      #1;
      rst_n = 1'b1;
      tick();
      tests++;
      if (rbus.gnt !== 4'b0010 || rbus.gnt_id !== 2'b01 || rbus.busy !== 1'b1) begin
         errors++;
         $display("FAIL arst_regrant got gnt=%b id=%b busy=%b want 0010/01/1",
                  rbus.gnt, rbus.gnt_id, rbus.busy);
      end
      rbus.req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_race();
      do_reset();
      rbus.req = 4'b0001;
      tick();
      rbus.req = 4'b0101;
      tick();
      rbus.req = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if (rbus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL race_pulse_lost[%0d] got gnt=%b want 0001", i, rbus.gnt);
         end
      end
      rbus.req = 4'b0000;
      tick();
      tick();
      tests++;
      if (rbus.gnt !== 4'b0000) begin
         errors++;
         $display("FAIL race_pulse_idle got gnt=%b want 0000", rbus.gnt);
      end

      // Owner 0 drops exactly when hold has saturated with requester 1 waiting.
      do_reset();
      rbus.req = 4'b0011;
      tick();
      tick();
      rbus.req = 4'b0010;
      tick();
      tests++;
      if (rbus.gnt !== 4'b0000 || rbus.busy !== 1'b0) begin
         errors++;
         $display("FAIL race_drop_gap got gnt=%b busy=%b want 0000/0", rbus.gnt, rbus.busy);
      end
      rbus.req = 4'b0011;
      tick();
      tests++;
      if (rbus.gnt !== 4'b0010 || rbus.gnt_id !== 2'b01) begin
         errors++;
         $display("FAIL race_drop_ptr got gnt=%b id=%b want 0010/01", rbus.gnt, rbus.gnt_id);
      end
      rbus.req = 4'b0000;
      tick();
      tick();
   endtask

   initial begin
      tests    = 0;
      errors   = 0;
      rst_n    = 1'b0;
      rbus.req = 4'b0000;
      fbus.req = 4'b0000;
      #2;
      test_reset();
      test_fixed();
      test_rr_rotation();
      test_lone();
      test_async_reset();
      test_race();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
